// File: rtl/display_mux_scheduler.sv
// display_mux_scheduler: drives one shared hex decoder for two digits, with a blanking lead-in per slot and frame-latched updates.
// Optional macro DISP_DIM_EN adds a dim[2:0] input that shortens the lit part of each show interval.
module display_mux_scheduler #(
  parameter int REFRESH_CYCLES = 6000,
  parameter int BLANK_CYCLES   = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic       upd_req,
`ifdef DISP_DIM_EN
  input  logic [2:0] dim,
`endif
  output logic       upd_ack,
  output logic [3:0] s,
  output logic       blank,
  output logic       en1,
  output logic       en2,
  output logic       frame_tick
);
  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_CYCLES - 1);
  typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] sh0, sh1, s_n;
  logic boundary, load, lit;
`ifdef DISP_DIM_EN
  localparam int DIM_STEP = (REFRESH_CYCLES - BLANK_CYCLES) / 8;
  logic [2:0] dim_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) dim_q <= '0;
    else if (boundary) dim_q <= dim;
  assign lit = int'(cnt_n) < REFRESH_CYCLES - int'(dim_q) * DIM_STEP;
`else
  assign lit = 1'b1;
`endif
  always_comb begin
    boundary = state == SHOW1 && cnt == SLOT_LAST;
    load     = boundary && upd_req;
    cnt_n    = cnt == SLOT_LAST ? '0 : cnt + CW'(1);
    state_n  = state == BLANK0 && cnt == BLANK_LAST ? SHOW0 :
               state == SHOW0  && cnt == SLOT_LAST  ? BLANK1 :
               state == BLANK1 && cnt == BLANK_LAST ? SHOW1 :
               boundary                             ? BLANK0 : state;
    // the digit value only moves while the display is blanked
    s_n      = state_n == BLANK0 && state != BLANK0 ? (load ? d0 : sh0) :
               state_n == BLANK1 && state != BLANK1 ? sh1 : s;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BLANK0;
      cnt        <= '0;
      sh0        <= '0;
      sh1        <= '0;
      s          <= '0;
      blank      <= 1'b1;
      en1        <= 1'b0;
      en2        <= 1'b0;
      upd_ack    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      if (load) begin
        sh0 <= d0;
        sh1 <= d1;
      end
      s          <= s_n;
      blank      <= state_n == BLANK0 || state_n == BLANK1;
      en1        <= state_n == SHOW0 && lit;
      en2        <= state_n == SHOW1 && lit;
      upd_ack    <= load;
      frame_tick <= state_n == SHOW1 && cnt_n == SLOT_LAST;
    end
  end
endmodule

// File: tb/tb_display_mux_scheduler.sv
// tb_display_mux_scheduler: directed vector table plus hand sequences for handshake, invariants and async reset.
module tb_display_mux_scheduler;
  logic clk = 1'b0, reset = 1'b1, upd_req = 1'b0;
  logic [3:0] d0 = '0, d1 = '0;
  logic upd_ack, blank, en1, en2, frame_tick;
  logic [3:0] s;
  int checks = 0, errors = 0;
  display_mux_scheduler #(.REFRESH_CYCLES(10), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .d0(d0), .d1(d1), .upd_req(upd_req),
    .upd_ack(upd_ack), .s(s), .blank(blank), .en1(en1), .en2(en2), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  typedef struct {
    int cyc;
    logic req;
    logic [3:0] d0, d1;
    logic [8:0] exp;
  } vec_t;
  vec_t tv[15];
  function automatic vec_t v(int c, logic r, logic [3:0] a, logic [3:0] b,
                             logic e1, logic e2, logic bl, logic ft, logic ak, logic [3:0] sv);
    v.cyc = c; v.req = r; v.d0 = a; v.d1 = b;
    v.exp = {e1, e2, bl, ft, ak, sv};
  endfunction
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic [8:0] outs();
    return {en1, en2, blank, frame_tick, upd_ack, s};
  endfunction
  initial begin
    int cur, acks, last;
    logic [3:0] s_prev;
    logic ft_prev, req_prev;
    tv[0]  = v(0,  0, 4'h0, 4'h0, 0, 0, 1, 0, 0, 4'h0);
    tv[1]  = v(2,  0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 4'h0);
    tv[2]  = v(5,  1, 4'h3, 4'hA, 1, 0, 0, 0, 0, 4'h0);
    tv[3]  = v(9,  1, 4'h3, 4'hA, 1, 0, 0, 0, 0, 4'h0);
    tv[4]  = v(10, 1, 4'h3, 4'hA, 0, 0, 1, 0, 0, 4'h0);
    tv[5]  = v(12, 1, 4'h3, 4'hA, 0, 1, 0, 0, 0, 4'h0);
    tv[6]  = v(19, 1, 4'h3, 4'hA, 0, 1, 0, 1, 0, 4'h0);
    tv[7]  = v(20, 0, 4'h7, 4'h5, 0, 0, 1, 0, 1, 4'h3);
    tv[8]  = v(21, 0, 4'h7, 4'h5, 0, 0, 1, 0, 0, 4'h3);
    tv[9]  = v(22, 0, 4'h7, 4'h5, 1, 0, 0, 0, 0, 4'h3);
    tv[10] = v(30, 0, 4'h7, 4'h5, 0, 0, 1, 0, 0, 4'hA);
    tv[11] = v(32, 0, 4'h7, 4'h5, 0, 1, 0, 0, 0, 4'hA);
    tv[12] = v(39, 0, 4'h7, 4'h5, 0, 1, 0, 1, 0, 4'hA);
    tv[13] = v(40, 0, 4'h7, 4'h5, 0, 0, 1, 0, 0, 4'h3);
    tv[14] = v(50, 0, 4'h7, 4'h5, 0, 0, 1, 0, 0, 4'hA);
    step(2);
    chk("reset_state", outs(), 9'b0_0_1_0_0_0000);
    reset = 1'b0;
    cur = 0;
    // cycle N means #1 after the Nth clock edge following reset release
    for (int i = 0; i < 15; i++) begin
      step(tv[i].cyc - cur);
      cur = tv[i].cyc;
      upd_req = tv[i].req; d0 = tv[i].d0; d1 = tv[i].d1;
      chk($sformatf("vec_c%0d{en1,en2,blank,ft,ack,s}", cur), outs(), tv[i].exp);
    end
    upd_req = 1'b1; d0 = 4'h1;
    acks = 0; last = -1;
    for (int c = 51; c <= 110; c++) begin
      step(1);
      if (upd_ack) begin
        acks++;
        chk($sformatf("held_req_s_c%0d", c), s, 4'(1 + (c - 60) / 20));
        chk($sformatf("held_req_ack_cycle_%0d", acks), c, 60 + 20 * (acks - 1));
        last = c;
      end
      d0 = 4'(1 + (c - 40) / 20);
    end
    chk("held_req_ack_count", acks, 3);
    upd_req = 1'b0;
    s_prev = s; ft_prev = frame_tick; req_prev = upd_req;
    for (int c = 0; c < 2000; c++) begin
      step(1);
      chk("rand_invariants",
          {en1 & en2, blank != !(en1 | en2), (en1 | en2) && s != s_prev, upd_ack != (ft_prev & req_prev)}, 4'b0);
      s_prev = s; ft_prev = frame_tick;
      upd_req = 1'($urandom); d0 = 4'($urandom); d1 = 4'($urandom);
      req_prev = upd_req;
    end
    reset = 1'b1; upd_req = 1'b0;
    step(2);
    reset = 1'b0; upd_req = 1'b1; d0 = 4'h5; d1 = 4'h9;
    step(20);
    upd_req = 1'b0;
    step(16);
    chk("show1_cnt6_before_reset", outs(), 9'b0_1_0_0_0_1001);
    #2 reset = 1'b1;
    #1 chk("async_reset_no_edge", outs(), 9'b0_0_1_0_0_0000);
    step(1);
    reset = 1'b0;
    step(2);
    chk("restart_show0_s0", outs(), 9'b1_0_0_0_0_0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
